// File: rtl/gain_ramp.sv
// Signed sample x unsigned gain stage with a per-sample gain ramp and valid handshake.
// Two register stages: operand capture, then the scaled product.
module gain_ramp #(
  parameter int WAVE_W     = 20,
  parameter int GAIN_W     = 8,
  parameter int RAMP_STEP  = 4,
  parameter int GAIN_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WAVE_W-1:0] wave_in,
  input  logic              gain_load,
  input  logic [GAIN_W-1:0] gain_in,
  input  logic              mute,
  output logic              out_valid,
  output logic [WAVE_W-1:0] wave_out,
  output logic [GAIN_W-1:0] cur_gain,
  output logic              ramping
);

  localparam int P_W = WAVE_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(GAIN_RESET);
  localparam logic [GAIN_W:0]   STEP_EXT  = (GAIN_W+1)'(RAMP_STEP);

  logic [GAIN_W-1:0] target_reg;
  logic [GAIN_W-1:0] cur_gain_reg;
  logic [GAIN_W-1:0] cur_gain_next;
  logic [GAIN_W-1:0] eff_gain;

  logic              s1_valid_reg;
  logic [WAVE_W-1:0] s1_wave_reg;
  logic [GAIN_W-1:0] s1_gain_reg;

  logic              out_valid_reg;
  logic [WAVE_W-1:0] wave_out_reg;
  logic [WAVE_W-1:0] wave_out_next;

  logic [GAIN_W:0]   cur_ext;
  logic [GAIN_W:0]   eff_ext;
  logic [GAIN_W:0]   sum_up;
  logic [GAIN_W:0]   sum_dn;

  logic signed [P_W-1:0] wave_sx;
  logic signed [P_W-1:0] gain_zx;
  logic signed [P_W-1:0] product;

  assign eff_gain = mute ? '0 : target_reg;

  // One bit of headroom so neither direction of the ramp can wrap.
  assign cur_ext = {1'b0, cur_gain_reg};
  assign eff_ext = {1'b0, eff_gain};
  assign sum_up  = cur_ext + STEP_EXT;
  assign sum_dn  = cur_ext - STEP_EXT;

  always_comb begin
    cur_gain_next = cur_gain_reg;
    if (cur_ext < eff_ext) begin
      cur_gain_next = (sum_up >= eff_ext) ? eff_gain : sum_up[GAIN_W-1:0];
    end else if (cur_ext > eff_ext) begin
      cur_gain_next = (cur_ext <= eff_ext + STEP_EXT) ? eff_gain : sum_dn[GAIN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_reg   <= GAIN_INIT;
      cur_gain_reg <= GAIN_INIT;
    end else begin
      if (gain_load) begin
        target_reg <= gain_in;
      end
      if (in_valid) begin
        cur_gain_reg <= cur_gain_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_wave_reg  <= '0;
      s1_gain_reg  <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_wave_reg <= wave_in;
        s1_gain_reg <= cur_gain_reg;
      end
    end
  end

  // Gain is zero-extended so it multiplies as a non-negative signed operand.
  assign wave_sx       = {{(GAIN_W+1){s1_wave_reg[WAVE_W-1]}}, s1_wave_reg};
  assign gain_zx       = {{(WAVE_W+1){1'b0}}, s1_gain_reg};
  assign product       = wave_sx * gain_zx;
  assign wave_out_next = WAVE_W'(product >>> GAIN_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      wave_out_reg  <= '0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        wave_out_reg <= wave_out_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign wave_out  = wave_out_reg;
  assign cur_gain  = cur_gain_reg;
  assign ramping   = (cur_gain_reg != eff_gain);

endmodule

// File: tb/tb_gain_ramp.sv
// Directed bench for gain_ramp: ramp, signed math, mute, idle hold and reset cases.
`timescale 1ns/1ps
module tb_gain_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [19:0] wave_in;
  logic        gain_load;
  logic [7:0]  gain_in;
  logic        mute;
  logic        out_valid;
  logic [19:0] wave_out;
  logic [7:0]  cur_gain;
  logic        ramping;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  gain_ramp #(.WAVE_W(20), .GAIN_W(8), .RAMP_STEP(4), .GAIN_RESET(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wave_in(wave_in),
    .gain_load(gain_load), .gain_in(gain_in), .mute(mute),
    .out_valid(out_valid), .wave_out(wave_out), .cur_gain(cur_gain), .ramping(ramping)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference scaling: floor(wave * gain / 256) on the signed sample.
  function automatic logic [19:0] scale(input logic [19:0] w, input logic [7:0] g);
    longint p;
    longint q;
    p = longint'($signed(w)) * longint'(g);
    q = p >>> 8;
    return q[19:0];
  endfunction

  // Every output that appears is matched against the expected queue.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
      else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("wave_out", 32'(wave_out), 32'(e));
        $display("out: wave_out=0x%05h expected=0x%05h", wave_out, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_gain(input logic [7:0] g);
    gain_load = 1'b1;
    gain_in   = g;
    step();
    gain_load = 1'b0;
  endtask

  // Drives one sample; checks the gain it will be paired with.
  task automatic send(input logic [19:0] w, input logic [7:0] g, input logic [19:0] e);
    check("paired_gain", 32'(cur_gain), 32'(g));
    in_valid = 1'b1;
    wave_in  = w;
    exp_q.push_back(e);
    step();
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      wave_in  = 20'h0;
      exp_q.push_back(20'h0);
      step();
    end
    quiet(3);
  endtask

  initial begin
    // Reset with garbage on every input
    rst = 1'b1; in_valid = 1'b1; wave_in = 20'hABCDE;
    gain_load = 1'b1; gain_in = 8'hA5; mute = 1'b1;
    step(); step();
    rst = 1'b0; in_valid = 1'b0; gain_load = 1'b0; mute = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_wave_out", 32'(wave_out), 32'd0);
    check("rst_cur_gain", 32'(cur_gain), 32'd0);
    check("rst_ramping", 32'(ramping), 32'd0);
    $display("reset: cur_gain=0x%02h ramping=%0d", cur_gain, ramping);

    // Ramp up to full scale over 64 samples
    load_gain(8'hFF);
    for (int k = 0; k < 70; k++) begin
      logic [7:0] g;
      g = (4 * k > 255) ? 8'hFF : 8'(4 * k);
      if (k == 63) check("ramping_before_last_step", 32'(ramping), 32'd1);
      if (k == 64) check("ramping_after_64", 32'(ramping), 32'd0);
      if (k == 0) send(20'h7FFFF, g, 20'h00000);
      else if (k == 69) send(20'h7FFFF, g, 20'h7F7FF);
      else send(20'h7FFFF, g, scale(20'h7FFFF, g));
    end
    quiet(3);

    // Signed arithmetic
    send(20'h80000, 8'hFF, 20'h80800);
    quiet(3);
    load_gain(8'h80);
    settle(40);
    send(20'hFFFFF, 8'h80, 20'hFFFFF);
    send(20'h00001, 8'h80, 20'h00000);
    send(20'h40000, 8'h80, 20'h20000);
    quiet(3);

    // Mute ramp-down, then release with no jump
    load_gain(8'hFF);
    settle(40);
    mute = 1'b1;
    for (int k = 0; k < 10; k++) send(20'h40000, 8'(255 - 4 * k), scale(20'h40000, 8'(255 - 4 * k)));
    in_valid = 1'b0;
    mute = 1'b0;
    #1;
    check("unmute_cur_gain", 32'(cur_gain), 32'hD7);
    check("unmute_ramping", 32'(ramping), 32'd1);
    send(20'h40000, 8'hD7, 20'h35C00);
    send(20'h40000, 8'hDB, 20'h36C00);
    send(20'h40000, 8'hDF, 20'h37C00);
    quiet(3);

    // Idle hold: no ramp without samples
    load_gain(8'h00);
    settle(70);
    load_gain(8'h40);
    quiet(20);
    check("idle_cur_gain", 32'(cur_gain), 32'h00);
    check("idle_ramping", 32'(ramping), 32'd1);
    send(20'h7FFFF, 8'h00, 20'h00000);

    // Reset one cycle after an accepted mid-ramp sample
    send(20'h12345, 8'h04, scale(20'h12345, 8'h04));
    in_valid = 1'b0;
    rst = 1'b1;
    void'(exp_q.pop_back());
    step();
    rst = 1'b0;
    check("midrst_cur_gain", 32'(cur_gain), 32'h00);
    check("midrst_ramping", 32'(ramping), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    quiet(4);
    check("midrst_out_valid_late", 32'(out_valid), 32'd0);
    check("pending_outputs", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
